// File: rtl/aes_main_add_round_key_p_if.sv
// Bundle between the AddRoundKey engine (master) and its environment (slave):
// the ap_* handshake, the round index, the dual-port state RAM and the dual-port
// expanded-key read port.
interface aes_main_add_round_key_p_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned STATE_AW = 5,
  parameter int unsigned KEY_AW   = 9
);
  logic                ap_start;
  logic                ap_done;
  logic                ap_idle;
  logic                ap_ready;
  logic [3:0]          n;
  logic [STATE_AW-1:0] statemt_address0;
  logic [STATE_AW-1:0] statemt_address1;
  logic                statemt_ce0;
  logic                statemt_ce1;
  logic                statemt_we0;
  logic                statemt_we1;
  logic [DATA_W-1:0]   statemt_d0;
  logic [DATA_W-1:0]   statemt_d1;
  logic [DATA_W-1:0]   statemt_q0;
  logic [DATA_W-1:0]   statemt_q1;
  logic [KEY_AW-1:0]   key_address0;
  logic [KEY_AW-1:0]   key_address1;
  logic                key_ce0;
  logic                key_ce1;
  logic [7:0]          key_q0;
  logic [7:0]          key_q1;

  modport master (
    input  ap_start, n, statemt_q0, statemt_q1, key_q0, key_q1,
    output ap_done, ap_idle, ap_ready,
           statemt_address0, statemt_address1, statemt_ce0, statemt_ce1,
           statemt_we0, statemt_we1, statemt_d0, statemt_d1,
           key_address0, key_address1, key_ce0, key_ce1
  );

  modport slave (
    output ap_start, n, statemt_q0, statemt_q1, key_q0, key_q1,
    input  ap_done, ap_idle, ap_ready,
           statemt_address0, statemt_address1, statemt_ce0, statemt_ce1,
           statemt_we0, statemt_we1, statemt_d0, statemt_d1,
           key_address0, key_address1, key_ce0, key_ce1
  );
endinterface

// File: rtl/aes_main_add_round_key_p.sv
// Parametrised AES/Rijndael AddRoundKey stage: XORs round key n into an
// NB-column state held in an external dual-port RAM, two rows per access pair.
// Optional build macro AES_ARK_BYTE_MASK_EN: state words are reduced to their
// low byte before the XOR, so written words carry zeros above bit 7.
module aes_main_add_round_key_p #(
  parameter int unsigned NB         = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STATE_AW   = 5,
  parameter int unsigned KEY_AW     = 9,
  parameter int unsigned KEY_STRIDE = 120
) (
  input logic                          ap_clk,
  input logic                          ap_rst,
  aes_main_add_round_key_p_if.master   bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_LOOP = 6'b000010,
    S_RD01 = 6'b000100,
    S_RD23 = 6'b001000,
    S_WR01 = 6'b010000,
    S_WR23 = 6'b100000
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    j_q, j_d;
  logic [KEY_AW-1:0]   base_q, base_d;
  logic                done_q, done_d;
  logic                ce_q, ce_d;
  logic                we_q, we_d;
  logic                kce_q, kce_d;
  logic [STATE_AW-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [KEY_AW-1:0]   kaddr0_q, kaddr0_d, kaddr1_q, kaddr1_d;
  logic [DATA_W-1:0]   d0_q, d0_d, d1_q, d1_d;

  function automatic logic [DATA_W-1:0] mix(input logic [DATA_W-1:0] q, input logic [7:0] k);
`ifdef AES_ARK_BYTE_MASK_EN
    return DATA_W'(q[7:0] ^ k);
`else
    return q ^ DATA_W'(k);
`endif
  endfunction

  function automatic logic [STATE_AW-1:0] st_addr(input logic [CNT_W-1:0] col, input int unsigned row);
    return STATE_AW'(32'(col) * 32'd4 + row);
  endfunction

  // Key address wraps modulo 2^KEY_AW by truncation
  function automatic logic [KEY_AW-1:0] key_addr(input logic [CNT_W-1:0] col,
                                                 input logic [KEY_AW-1:0] b,
                                                 input int unsigned row);
    return KEY_AW'(row * KEY_STRIDE + 32'(b) + 32'(col));
  endfunction

  // Next state, then outputs decoded for the cycle the next state will occupy
  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    base_d   = base_q;
    done_d   = 1'b0;
    ce_d     = 1'b0;
    we_d     = 1'b0;
    kce_d    = 1'b0;
    addr0_d  = addr0_q;
    addr1_d  = addr1_q;
    kaddr0_d = kaddr0_q;
    kaddr1_d = kaddr1_q;
    d0_d     = d0_q;
    d1_d     = d1_q;

    case (state_q)
      S_IDLE: begin
        if (bus.ap_start) begin
          base_d  = KEY_AW'(32'(bus.n) * NB);
          j_d     = '0;
          state_d = S_LOOP;
        end
      end
      S_LOOP: state_d = (j_q == CNT_W'(NB)) ? S_IDLE : S_RD01;
      S_RD01: state_d = S_RD23;
      S_RD23: begin
        d1_d    = mix(bus.statemt_q1, bus.key_q1);
        d0_d    = mix(bus.statemt_q0, bus.key_q0);
        state_d = S_WR01;
      end
      S_WR01: begin
        d1_d    = mix(bus.statemt_q1, bus.key_q1);
        d0_d    = mix(bus.statemt_q0, bus.key_q0);
        state_d = S_WR23;
      end
      S_WR23: begin
        j_d     = j_q + 1'b1;
        state_d = S_LOOP;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_LOOP: done_d = (j_d == CNT_W'(NB));
      S_RD01: begin
        ce_d     = 1'b1;
        kce_d    = 1'b1;
        addr1_d  = st_addr(j_d, 0);
        addr0_d  = st_addr(j_d, 1);
        kaddr1_d = key_addr(j_d, base_d, 0);
        kaddr0_d = key_addr(j_d, base_d, 1);
      end
      S_RD23: begin
        ce_d     = 1'b1;
        kce_d    = 1'b1;
        addr1_d  = st_addr(j_d, 2);
        addr0_d  = st_addr(j_d, 3);
        kaddr1_d = key_addr(j_d, base_d, 2);
        kaddr0_d = key_addr(j_d, base_d, 3);
      end
      S_WR01: begin
        ce_d    = 1'b1;
        we_d    = 1'b1;
        addr1_d = st_addr(j_d, 0);
        addr0_d = st_addr(j_d, 1);
      end
      S_WR23: begin
        ce_d    = 1'b1;
        we_d    = 1'b1;
        addr1_d = st_addr(j_d, 2);
        addr0_d = st_addr(j_d, 3);
      end
      default: ;
    endcase
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q  <= S_IDLE;
      j_q      <= '0;
      base_q   <= '0;
      done_q   <= 1'b0;
      ce_q     <= 1'b0;
      we_q     <= 1'b0;
      kce_q    <= 1'b0;
      addr0_q  <= '0;
      addr1_q  <= '0;
      kaddr0_q <= '0;
      kaddr1_q <= '0;
      d0_q     <= '0;
      d1_q     <= '0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      base_q   <= base_d;
      done_q   <= done_d;
      ce_q     <= ce_d;
      we_q     <= we_d;
      kce_q    <= kce_d;
      addr0_q  <= addr0_d;
      addr1_q  <= addr1_d;
      kaddr0_q <= kaddr0_d;
      kaddr1_q <= kaddr1_d;
      d0_q     <= d0_d;
      d1_q     <= d1_d;
    end
  end

  assign bus.ap_done          = done_q;
  assign bus.ap_ready         = done_q;
  assign bus.ap_idle          = (state_q == S_IDLE) && !bus.ap_start;
  assign bus.statemt_ce0      = ce_q;
  assign bus.statemt_ce1      = ce_q;
  assign bus.statemt_we0      = we_q;
  assign bus.statemt_we1      = we_q;
  assign bus.statemt_address0 = addr0_q;
  assign bus.statemt_address1 = addr1_q;
  assign bus.statemt_d0       = d0_q;
  assign bus.statemt_d1       = d1_q;
  assign bus.key_ce0          = kce_q;
  assign bus.key_ce1          = kce_q;
  assign bus.key_address0     = kaddr0_q;
  assign bus.key_address1     = kaddr1_q;

endmodule

// File: tb/tb_aes_main_add_round_key_p.sv
// Directed bench for aes_main_add_round_key_p: NB=4 and NB=8 instances with
// behavioural state RAM / key memories.
module tb_aes_main_add_round_key_p;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  aes_main_add_round_key_p_if #(.DATA_W(32), .STATE_AW(5), .KEY_AW(9))  b4 ();
  aes_main_add_round_key_p_if #(.DATA_W(32), .STATE_AW(5), .KEY_AW(10)) b8 ();

  aes_main_add_round_key_p #(.NB(4), .DATA_W(32), .STATE_AW(5), .KEY_AW(9), .KEY_STRIDE(120))
    u4 (.ap_clk(clk), .ap_rst(rst), .bus(b4.master));
  aes_main_add_round_key_p #(.NB(8), .DATA_W(32), .STATE_AW(5), .KEY_AW(10), .KEY_STRIDE(240))
    u8 (.ap_clk(clk), .ap_rst(rst), .bus(b8.master));

  logic [31:0] smem4 [32];
  logic [7:0]  kmem4 [512];
  logic [31:0] smem8 [32];
  logic [7:0]  kmem8 [1024];
  bit          kseen4 [512];
  int          kreads4;
  int          wcnt8 [32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // NB=4 memories: reads before writes, 1-cycle read latency
  always @(posedge clk) begin
    if (b4.statemt_ce0) b4.statemt_q0 <= smem4[b4.statemt_address0];
    if (b4.statemt_ce1) b4.statemt_q1 <= smem4[b4.statemt_address1];
    if (b4.statemt_ce0 && b4.statemt_we0) smem4[b4.statemt_address0] = b4.statemt_d0;
    if (b4.statemt_ce1 && b4.statemt_we1) smem4[b4.statemt_address1] = b4.statemt_d1;
    if (b4.key_ce0) begin b4.key_q0 <= kmem4[b4.key_address0]; kseen4[b4.key_address0] = 1'b1; kreads4++; end
    if (b4.key_ce1) begin b4.key_q1 <= kmem4[b4.key_address1]; kseen4[b4.key_address1] = 1'b1; kreads4++; end
  end

  // NB=8 memories with per-address write counters
  always @(posedge clk) begin
    if (b8.statemt_ce0) b8.statemt_q0 <= smem8[b8.statemt_address0];
    if (b8.statemt_ce1) b8.statemt_q1 <= smem8[b8.statemt_address1];
    if (b8.statemt_ce0 && b8.statemt_we0) begin smem8[b8.statemt_address0] = b8.statemt_d0; wcnt8[b8.statemt_address0]++; end
    if (b8.statemt_ce1 && b8.statemt_we1) begin smem8[b8.statemt_address1] = b8.statemt_d1; wcnt8[b8.statemt_address1]++; end
    if (b8.key_ce0) b8.key_q0 <= kmem8[b8.key_address0];
    if (b8.key_ce1) b8.key_q1 <= kmem8[b8.key_address1];
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int w);
    return (w == 4) ? b4.ap_done : b8.ap_done;
  endfunction

  // Start a run with round index nv, scramble n after acceptance, count cycles to done
  task automatic run(input int which, input logic [3:0] nv, output int cyc);
    @(negedge clk);
    if (which == 4) begin b4.n = nv; b4.ap_start = 1'b1; end
    else            begin b8.n = nv; b8.ap_start = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    if (which == 4) begin b4.ap_start = 1'b0; b4.n = nv ^ 4'hF; end
    else            begin b8.ap_start = 1'b0; b8.n = nv ^ 4'hF; end
    cyc = 1;
    while (!done_of(which) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("done_seen_u%0d", which), 32'(done_of(which)), 32'd1);
  endtask

  initial begin
    int c;
    int bad;
    int wbad;
    int pulses;
    int high_cycles;
    int pos [3];
    bit found;
    logic [31:0] e;
    logic [31:0] exp_mask;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    b4.ap_start = 1'b0; b4.n = 4'd0;
    b8.ap_start = 1'b0; b8.n = 4'd0;
    kreads4 = 0;
    for (int a = 0; a < 512; a++)  kmem4[a] = 8'(16 * (a / 120) + a % 120);
    for (int a = 0; a < 1024; a++) kmem8[a] = 8'(16 * (a / 240) + a % 240);
    for (int k = 0; k < 32; k++) begin smem4[k] = 32'(k); smem8[k] = 32'(k); wcnt8[k] = 0; end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done",  32'(b4.ap_done), 32'd0);
    chk("rst_ready", 32'(b4.ap_ready), 32'd0);
    chk("rst_ce",    32'({b4.statemt_ce0, b4.statemt_ce1, b4.key_ce0, b4.key_ce1}), 32'd0);
    chk("rst_we",    32'({b4.statemt_we0, b4.statemt_we1, b8.statemt_we0, b8.statemt_we1}), 32'd0);
    chk("rst_idle",  32'(b4.ap_idle), 32'd1);
    b4.ap_start = 1'b1;
    #1;
    chk("idle_follows_start", 32'(b4.ap_idle), 32'd0);
    b4.ap_start = 1'b0;
    rst = 1'b0;

    // NB=4, n=0
    run(4, 4'd0, c);
    chk("t1_done_cycle", 32'(c), 32'd21);
    chk("t1_ready_eq_done", 32'(b4.ap_ready), 32'd1);
    @(negedge clk);
    chk("t1_done_width", 32'(b4.ap_done), 32'd0);
    chk("t1_back_idle", 32'(b4.ap_idle), 32'd1);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      e = 32'(k) ^ 32'(16 * (k % 4) + k / 4);
      if (smem4[k] !== e) bad++;
    end
    chk("t1_words_bad", 32'(bad), 32'd0);
    chk("t1_w6",  smem4[6],  32'h27);
    chk("t1_w15", smem4[15], 32'h3C);
    chk("t1_w16_untouched", smem4[16], 32'd16);

    // NB=4, n=3, upper state bits and key override on word 0
    for (int k = 0; k < 32; k++) smem4[k] = 32'(k);
    smem4[0] = 32'hABCD0012;
    kmem4[12] = 8'h34;
    for (int a = 0; a < 512; a++) kseen4[a] = 1'b0;
    kreads4 = 0;
`ifdef AES_ARK_BYTE_MASK_EN
    exp_mask = 32'h00000026;
`else
    exp_mask = 32'hABCD0026;
`endif
    run(4, 4'd3, c);
    chk("t2_done_cycle", 32'(c), 32'd21);
    chk("t2_w0_upper_bits", smem4[0], exp_mask);
    chk("t2_w9", smem4[9], 32'h17);
    chk("t2_w6_key253", smem4[6], 32'h2B);
    chk("t2_key_addr253", 32'(kseen4[253]), 32'd1);
    chk("t2_key_addr12", 32'(kseen4[12]), 32'd1);
    chk("t2_key_reads", 32'(kreads4), 32'd16);
    bad = 0;
    for (int k = 1; k < 16; k++) begin
      e = 32'(k) ^ 32'(16 * (k % 4) + 12 + k / 4);
      if (smem4[k] !== e) bad++;
    end
    chk("t2_words_bad", 32'(bad), 32'd0);
    kmem4[12] = 8'(12);

    // NB=8, stride 240, n=1
    for (int k = 0; k < 32; k++) begin smem8[k] = 32'(k + 'h40); wcnt8[k] = 0; end
    run(8, 4'd1, c);
    chk("t3_done_cycle", 32'(c), 32'd41);
    bad = 0;
    wbad = 0;
    for (int k = 0; k < 32; k++) begin
      e = 32'(k + 'h40) ^ 32'(16 * (k % 4) + 8 + k / 4);
      if (smem8[k] !== e) bad++;
      if (wcnt8[k] != 1) wbad++;
    end
    chk("t3_words_bad", 32'(bad), 32'd0);
    chk("t3_write_once_bad", 32'(wbad), 32'd0);
    chk("t3_w9",  smem8[9],  32'h53);
    chk("t3_w31", smem8[31], 32'h60);

    // Reset during WR01 of column 2
    for (int k = 0; k < 32; k++) smem4[k] = 32'(k);
    @(negedge clk);
    b4.n = 4'd0;
    b4.ap_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b4.ap_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (b4.statemt_we1 && b4.statemt_address1 == 5'd8) found = 1'b1;
      else @(negedge clk);
    end
    chk("t4_reached_wr01_col2", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_we_low", 32'({b4.statemt_we0, b4.statemt_we1}), 32'd0);
    chk("t4_ce_low", 32'({b4.statemt_ce0, b4.statemt_ce1}), 32'd0);
    chk("t4_idle", 32'(b4.ap_idle), 32'd1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_stays_quiet", 32'({b4.statemt_we0, b4.statemt_we1, b4.ap_done}), 32'd0);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      e = 32'(k) ^ 32'(16 * (k % 4) + k / 4);
      if (smem4[k] !== e) bad++;
    end
    for (int k = 10; k < 16; k++) if (smem4[k] !== 32'(k)) bad++;
    chk("t4_words_bad", 32'(bad), 32'd0);

    // ap_start held high: runs separated by exactly one IDLE cycle
    @(negedge clk);
    b4.ap_start = 1'b1;
    pulses = 0;
    high_cycles = 0;
    for (int i = 0; i < 3; i++) pos[i] = 0;
    for (int cy = 1; cy <= 72; cy++) begin
      @(negedge clk);
      if (b4.ap_done) begin
        if (pulses < 3) pos[pulses] = cy;
        pulses++;
        if (pulses == 3) b4.ap_start = 1'b0;
      end
      if (b4.ap_done) high_cycles++;
    end
    chk("t5_pulses", 32'(pulses), 32'd3);
    chk("t5_done_high_cycles", 32'(high_cycles), 32'd3);
    chk("t5_first_done", 32'(pos[0]), 32'd21);
    chk("t5_second_done", 32'(pos[1]), 32'd43);
    chk("t5_third_done", 32'(pos[2]), 32'd65);
    chk("t5_idle_after", 32'(b4.ap_idle), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
